clint: RTL and testbench

CLINT -- requirements
Module: clint

---
 rtl/clint_pkg.sv | 45 ++++
 rtl/clint.sv | 158 +++++++++++++++
 tb/tb_clint.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/clint_pkg.sv
// Shared CLINT definitions: instruction encodings, CSR addresses, trap causes,
// sequencer states and mstatus update helpers.
package clint_pkg;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_ASYNC  = 32'h8000_000B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEPC,
        S_MCAUSE,
        S_MSTATUS,
        S_CALL,
        S_MRET,
        S_RET
    } state_e;

    // Trap entry: MPIE <- MIE, MIE <- 0.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r    = m;
        r[7] = m[3];
        r[3] = 1'b0;
        return r;
    endfunction

    // Trap return: MIE <- MPIE, MPIE <- 1.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r    = m;
        r[3] = m[7];
        r[7] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/clint.sv
// Core-local interrupt controller: sequences the CSR writes for trap entry
// and MRET, then issues a one-cycle redirect to the execute stage.
module clint
    import clint_pkg::*;
#(
    parameter int INT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INT_WIDTH-1:0] int_flag_i,
    input  logic [31:0]          inst_i,
    input  logic [31:0]          inst_addr_i,
    input  logic                 jump_flag_i,
    input  logic [31:0]          jump_addr_i,
    input  logic [31:0]          csr_mtvec_i,
    input  logic [31:0]          csr_mepc_i,
    input  logic [31:0]          csr_mstatus_i,
    output logic                 hold_flag_o,
    output logic                 we_o,
    output logic [11:0]          waddr_o,
    output logic [31:0]          data_o,
    output logic                 int_assert_o,
    output logic [31:0]          int_addr_o
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_cause;
    logic        r_we;
    logic [11:0] r_waddr;
    logic [31:0] r_data;
    logic        r_assert;
    logic [31:0] r_int_addr;

    logic        w_idle;
    logic        w_is_sync;
    logic        w_is_mret;
    logic        w_is_async;
    logic        w_trap;
    logic        w_mret;
    logic [31:0] w_epc;
    logic [31:0] w_cause;
    logic        w_we_nxt;
    logic [11:0] w_waddr_nxt;
    logic [31:0] w_data_nxt;
    logic        w_assert_nxt;
    logic [31:0] w_int_addr_nxt;

    assign w_idle     = (r_state == S_IDLE);
    assign w_is_sync  = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
    assign w_is_mret  = (inst_i == INST_MRET);
    assign w_is_async = (|int_flag_i) && csr_mstatus_i[3];

    assign w_trap = w_idle && (w_is_sync || (!w_is_mret && w_is_async));
    assign w_mret = w_idle && !w_is_sync && w_is_mret;

    // A redirect in flight takes precedence as the async return point.
    assign w_epc   = (!w_is_sync && jump_flag_i) ? jump_addr_i : inst_addr_i;
    assign w_cause = (inst_i == INST_ECALL)  ? CAUSE_ECALL  :
                     (inst_i == INST_EBREAK) ? CAUSE_EBREAK : CAUSE_ASYNC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_trap) begin
                    w_state_nxt = S_MEPC;
                end else if (w_mret) begin
                    w_state_nxt = S_MRET;
                end
            end
            S_MEPC:    w_state_nxt = S_MCAUSE;
            S_MCAUSE:  w_state_nxt = S_MSTATUS;
            S_MSTATUS: w_state_nxt = S_CALL;
            S_CALL:    w_state_nxt = S_IDLE;
            S_MRET:    w_state_nxt = S_RET;
            S_RET:     w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Computes what the output registers show in the next state's cycle.
    always_comb begin
        w_we_nxt       = 1'b0;
        w_waddr_nxt    = r_waddr;
        w_data_nxt     = r_data;
        w_assert_nxt   = 1'b0;
        w_int_addr_nxt = r_int_addr;
        case (r_state)
            S_IDLE: begin
                if (w_trap) begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = CSR_MEPC;
                    w_data_nxt  = w_epc;
                end else if (w_mret) begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = CSR_MSTATUS;
                    w_data_nxt  = mret_mstatus(csr_mstatus_i);
                end
            end
            S_MEPC: begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = CSR_MCAUSE;
                w_data_nxt  = r_cause;
            end
            S_MCAUSE: begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = CSR_MSTATUS;
                w_data_nxt  = trap_mstatus(csr_mstatus_i);
            end
            S_MSTATUS: begin
                w_assert_nxt   = 1'b1;
                w_int_addr_nxt = csr_mtvec_i;
            end
            S_MRET: begin
                w_assert_nxt   = 1'b1;
                w_int_addr_nxt = csr_mepc_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cause    <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_data     <= '0;
            r_assert   <= 1'b0;
            r_int_addr <= '0;
        end else begin
            if (w_trap) begin
                r_cause <= w_cause;
            end
            r_we       <= w_we_nxt;
            r_waddr    <= w_waddr_nxt;
            r_data     <= w_data_nxt;
            r_assert   <= w_assert_nxt;
            r_int_addr <= w_int_addr_nxt;
        end
    end

    assign hold_flag_o  = w_trap || w_mret || !w_idle;
    assign we_o         = r_we;
    assign waddr_o      = r_waddr;
    assign data_o       = r_data;
    assign int_assert_o = r_assert;
    assign int_addr_o   = r_int_addr;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: a cycle-indexed schedule model checked every
// cycle, plus literal expectations taken from hand-worked scenarios.
module tb_clint;

    localparam int SZ = 2048;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET = 32'h3020_0073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  int_flag_i = '0;
    logic [31:0] inst_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic [31:0] csr_mtvec_i = '0;
    logic [31:0] csr_mepc_i = '0;
    logic [31:0] csr_mstatus_i = '0;
    logic        hold_flag_o;
    logic        we_o;
    logic [11:0] waddr_o;
    logic [31:0] data_o;
    logic        int_assert_o;
    logic [31:0] int_addr_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    clint #(.INT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .int_flag_i(int_flag_i), .inst_i(inst_i),
        .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
        .hold_flag_o(hold_flag_o), .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
        .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: on acceptance at cycle T, write the whole future of the event
    // into per-cycle tables; outputs are then looked up by cycle number.
    logic        s_we   [SZ];
    logic [11:0] s_waddr[SZ];
    logic [31:0] s_data [SZ];
    logic        s_as   [SZ];
    logic [31:0] s_addr [SZ];
    int          busy_end = -1;
    logic        e_hold;
    logic [11:0] last_waddr = '0;
    logic [31:0] last_data = '0;
    logic [31:0] last_addr = '0;

    initial begin
        for (int i = 0; i < SZ; i++) begin
            s_we[i] = 1'b0; s_as[i] = 1'b0; s_waddr[i] = '0; s_data[i] = '0; s_addr[i] = '0;
        end
    end

    task automatic put_we(input int c, input logic [11:0] a, input logic [31:0] d);
        s_we[c] = 1'b1; s_waddr[c] = a; s_data[c] = d;
    endtask

    always @(negedge clk) begin : model
        logic [31:0] m;
        logic [31:0] cause;
        logic        is_sync;
        logic        is_async;
        m = csr_mstatus_i;
        if (!rst_n) begin
            for (int i = cyc; i < SZ; i++) begin
                s_we[i] = 1'b0; s_as[i] = 1'b0;
            end
            busy_end = -1;
            e_hold = 1'b0;
            last_waddr = '0; last_data = '0; last_addr = '0;
        end else begin
            is_sync  = (inst_i == ECALL) || (inst_i == EBREAK);
            is_async = (int_flag_i != 8'h00) && m[3];
            if (cyc > busy_end && cyc + 5 < SZ) begin
                if (is_sync || (inst_i != MRET && is_async)) begin
                    cause = (inst_i == ECALL) ? 32'd11 : (inst_i == EBREAK) ? 32'd3 : 32'h8000000B;
                    put_we(cyc + 1, 12'h341, (!is_sync && jump_flag_i) ? jump_addr_i : inst_addr_i);
                    put_we(cyc + 2, 12'h342, cause);
                    put_we(cyc + 3, 12'h300, (m & ~32'h88) | {24'h0, m[3], 7'h0});
                    s_as[cyc + 4] = 1'b1; s_addr[cyc + 4] = csr_mtvec_i;
                    busy_end = cyc + 4;
                end else if (inst_i == MRET) begin
                    put_we(cyc + 1, 12'h300, (m & ~32'h88) | 32'h80 | {28'h0, m[7], 3'h0});
                    s_as[cyc + 2] = 1'b1; s_addr[cyc + 2] = csr_mepc_i;
                    busy_end = cyc + 2;
                end
            end
            e_hold = (cyc <= busy_end);
            if (s_we[cyc]) begin
                last_waddr = s_waddr[cyc]; last_data = s_data[cyc];
            end
            if (s_as[cyc]) last_addr = s_addr[cyc];
        end
        chk("m_hold", {31'h0, hold_flag_o}, {31'h0, e_hold});
        chk("m_we", {31'h0, we_o}, {31'h0, rst_n && s_we[cyc]});
        chk("m_assert", {31'h0, int_assert_o}, {31'h0, rst_n && s_as[cyc]});
        chk("m_waddr", {20'h0, waddr_o}, {20'h0, last_waddr});
        chk("m_data", data_o, last_data);
        chk("m_int_addr", int_addr_o, last_addr);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) tick();
        at_neg();
        chk("rst_we", {31'h0, we_o}, 32'h0);
        chk("rst_hold", {31'h0, hold_flag_o}, 32'h0);
        chk("rst_data", data_o, 32'h0);
        tick();
        rst_n = 1'b1;
        inst_i = NOP; inst_addr_i = 32'hFC;
        repeat (2) tick();

        // ECALL at 0x100, mtvec 0x200, MIE set; an MRET at T+2 must be ignored
        inst_i = ECALL; inst_addr_i = 32'h100; csr_mtvec_i = 32'h200; csr_mstatus_i = 32'h8;
        at_neg(); chk("ecall_hold_T", {31'h0, hold_flag_o}, 32'h1);
        tick(); inst_i = NOP; inst_addr_i = 32'h104;
        at_neg(); chk("ecall_mepc_addr", {20'h0, waddr_o}, 32'h341); chk("ecall_mepc", data_o, 32'h100);
        tick(); inst_i = MRET;
        at_neg(); chk("ecall_mcause_addr", {20'h0, waddr_o}, 32'h342); chk("ecall_mcause", data_o, 32'd11);
        tick(); inst_i = NOP;
        at_neg(); chk("ecall_mstatus", data_o, 32'h80);
        tick();
        at_neg(); chk("ecall_assert", {31'h0, int_assert_o}, 32'h1); chk("ecall_target", int_addr_o, 32'h200);
        chk("ecall_hold_T4", {31'h0, hold_flag_o}, 32'h1);
        tick();
        at_neg(); chk("ecall_hold_T5", {31'h0, hold_flag_o}, 32'h0); chk("ecall_waddr_kept", {20'h0, waddr_o}, 32'h300);
        repeat (2) tick();

        // async interrupt while execute redirects
        inst_addr_i = 32'h108; int_flag_i = 8'h01; jump_flag_i = 1'b1; jump_addr_i = 32'h344;
        at_neg(); chk("async_hold_T", {31'h0, hold_flag_o}, 32'h1);
        tick(); int_flag_i = 8'h00; jump_flag_i = 1'b0;
        at_neg(); chk("async_mepc", data_o, 32'h344);
        tick();
        at_neg(); chk("async_mcause", data_o, 32'h8000000B);
        repeat (5) tick();

        // MRET
        inst_i = MRET; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
        at_neg(); chk("mret_hold_T", {31'h0, hold_flag_o}, 32'h1);
        tick(); inst_i = NOP;
        at_neg(); chk("mret_mstatus_addr", {20'h0, waddr_o}, 32'h300); chk("mret_mstatus", data_o, 32'h88);
        tick();
        at_neg(); chk("mret_assert", {31'h0, int_assert_o}, 32'h1); chk("mret_target", int_addr_o, 32'h104);
        tick();
        at_neg(); chk("mret_hold_end", {31'h0, hold_flag_o}, 32'h0);
        tick();

        // masked interrupts
        csr_mstatus_i = 32'h0; int_flag_i = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            at_neg(); chk("masked_hold", {31'h0, hold_flag_o}, 32'h0); chk("masked_we", {31'h0, we_o}, 32'h0);
            tick();
        end
        int_flag_i = 8'h00;

        // ECALL wins over a pending interrupt
        inst_i = ECALL; inst_addr_i = 32'h200; int_flag_i = 8'h01; csr_mstatus_i = 32'h8;
        tick(); inst_i = NOP; int_flag_i = 8'h00;
        tick();
        at_neg(); chk("prio_mcause", data_o, 32'd11);
        repeat (4) tick();

        // EBREAK cause
        inst_i = EBREAK; inst_addr_i = 32'h300;
        tick(); inst_i = NOP;
        tick();
        at_neg(); chk("ebreak_mcause", data_o, 32'd3);
        repeat (4) tick();

        // level interrupt held across the trap; MIE cleared by then
        inst_addr_i = 32'h400; int_flag_i = 8'h01; csr_mstatus_i = 32'h8;
        repeat (5) tick();
        csr_mstatus_i = 32'h80;
        at_neg(); chk("no_retrigger", {31'h0, hold_flag_o}, 32'h0);
        repeat (3) tick();
        int_flag_i = 8'h00;

        // reset in the middle of a trap
        inst_i = ECALL; inst_addr_i = 32'h500; csr_mstatus_i = 32'h8;
        tick(); inst_i = NOP;
        tick(); rst_n = 1'b0;
        at_neg(); chk("midrst_we", {31'h0, we_o}, 32'h0); chk("midrst_waddr", {20'h0, waddr_o}, 32'h0);
        chk("midrst_hold", {31'h0, hold_flag_o}, 32'h0);
        tick(); rst_n = 1'b1;
        repeat (3) tick();
        at_neg(); chk("postrst_assert", {31'h0, int_assert_o}, 32'h0); chk("postrst_data", data_o, 32'h0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
